// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: latches an MDU op, drives the multiplier or
// divider, stalls EX until the 64-bit result lands, then writes HI/LO. Optional macro: MDU_DIVZERO_BYPASS_EN.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_a, op_b;
  logic             sgn;
  logic [63:0]      res;

  logic one_hot, is_mul, bypass, accept, cap_mul, cap_div;

  always_comb begin
    one_hot = 1'b0;
    case (op_code)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: one_hot = 1'b1;
      default:                            one_hot = 1'b0;
    endcase
  end

  assign is_mul = op_code[3] | op_code[2];

`ifdef MDU_DIVZERO_BYPASS_EN
  assign bypass = !is_mul && (src_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    cap_mul   = 1'b0;
    cap_div   = 1'b0;
    stallreq  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid && !flush && one_hot) begin
          accept   = 1'b1;
          stallreq = 1'b1;
          state_nx = is_mul ? MUL : (bypass ? DONE : DIV);
        end
      end
      MUL: begin
        if (flush) begin
          state_nx = IDLE;
        end else begin
          stallreq = 1'b1;
          if (cnt == CNT_W'(MUL_LAT)) begin
            cap_mul  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DIV: begin
        if (flush) begin
          div_annul = 1'b1;
          state_nx  = IDLE;
        end else begin
          stallreq = 1'b1;
          if (div_ready) begin
            cap_div  = 1'b1;
            state_nx = DONE;
          end else begin
            div_start = 1'b1;
          end
        end
      end
      DONE: begin
        // op_valid is deliberately ignored here so a held instruction is not restarted
        if (flush) begin
          state_nx = IDLE;
        end else begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          if (!ex_hold) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      sgn   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a <= src_a;
        op_b <= src_b;
        sgn  <= op_code[3] | op_code[1];
        cnt  <= CNT_W'(1);
        if (bypass) res <= {src_a, 32'hFFFF_FFFF};
      end else if (state == MUL) begin
        cnt <= (cap_mul || flush) ? '0 : cnt + 1'b1;
      end
      if (cap_mul) res <= mul_result;
      if (cap_div) res <= div_result;
    end
  end

  assign mul_signed = sgn;
  assign mul_ina    = op_a;
  assign mul_inb    = op_b;
  assign div_signed = sgn;
  assign div_op1    = op_a;
  assign div_op2    = op_b;
  assign hi_wdata   = res[63:32];
  assign lo_wdata   = res[31:0];

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: behavioural multiplier/divider environment plus an
// arithmetic reference for HI/LO results, stall lengths and divider start counts.
module tb_mdu_ctrl;

  localparam int unsigned MUL_LAT = 2;
`ifdef MDU_DIVZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] OP_MULT = 4'b1000, OP_MULTU = 4'b0100,
                         OP_DIV  = 4'b0010, OP_DIVU  = 4'b0001;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush, ex_hold;
  logic [3:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_ina, mul_inb, div_op1, div_op2;
  logic [63:0] mul_result, div_result;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_vec = 0;
  int n_err = 0;
  int dlat  = 4;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .ex_hold(ex_hold),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready), .stallreq(stallreq),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  // Multiplier environment: product is stable as long as the operands are.
  always_comb begin
    if (mul_signed) mul_result = 64'(longint'($signed(mul_ina)) * longint'($signed(mul_inb)));
    else            mul_result = {32'b0, mul_ina} * {32'b0, mul_inb};
  end

  // Divider environment: ready dlat cycles after the first start, cleared by annul/rst.
  logic dbusy;
  int   dcnt;
  always_ff @(posedge clk) begin
    if (rst || div_annul) begin
      dbusy <= 1'b0;
      dcnt  <= 0;
    end else if (dbusy) begin
      if (div_ready) dbusy <= 1'b0;
      else           dcnt  <= dcnt + 1;
    end else if (div_start) begin
      dbusy <= 1'b1;
      dcnt  <= 1;
    end
  end
  assign div_ready = dbusy && (dcnt >= dlat);

  always_comb begin
    if (div_op2 == 32'h0)
      div_result = {div_op1, 32'hFFFF_FFFF};
    else if (div_signed && div_op1 == 32'h8000_0000 && div_op2 == 32'hFFFF_FFFF)
      div_result = {32'h0, 32'h8000_0000};
    else if (div_signed)
      div_result = {32'($signed(div_op1) % $signed(div_op2)), 32'($signed(div_op1) / $signed(div_op2))};
    else
      div_result = {div_op1 % div_op2, div_op1 / div_op2};
  end

  function automatic logic [63:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (c)
      OP_MULT:  return 64'(longint'(sa) * longint'(sb));
      OP_MULTU: return 64'({32'b0, a} * {32'b0, b});
      OP_DIV:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  return 64'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, 64'(stallreq), 64'(0));
    chk({tag, "_we"}, 64'({hi_we, lo_we}), 64'(0));
    chk({tag, "_start"}, 64'(div_start), 64'(0));
    chk({tag, "_annul"}, 64'(div_annul), 64'(0));
  endtask

  // One complete operation with EX holding the instruction until DONE exits.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int dl, input int hold);
    logic [63:0] e;
    int exp_st, exp_starts, st, starts, k;
    bit mul;
    mul = code[3] | code[2];
    e = ref_res(code, a, b);
    if (mul)                begin exp_st = MUL_LAT + 1; exp_starts = 0;  end
    else if (BYP && b == 0) begin exp_st = 1;           exp_starts = 0;  end
    else                    begin exp_st = dl + 2;      exp_starts = dl; end
    dlat = dl;
    next_cycle();
    op_valid = 1'b1; op_code = code; src_a = a; src_b = b; flush = 1'b0; ex_hold = (hold > 0);
    #1;
    chk("accept_stall", 64'(stallreq), 64'(1));
    st = 0; starts = 0; k = 0;
    while (stallreq && k < 200) begin
      st++;
      if (div_start) starts++;
      next_cycle();
      src_a = $urandom;
      src_b = $urandom;
      #1;
      k++;
    end
    chk("stall_cycles", 64'(st), 64'(exp_st));
    chk("start_cycles", 64'(starts), 64'(exp_starts));
    for (int h = 0; h <= hold; h++) begin
      chk("done_we", 64'({hi_we, lo_we}), 64'(2'b11));
      chk("done_data", {hi_wdata, lo_wdata}, e);
      chk("done_nostart", 64'({div_start, stallreq}), 64'(0));
      if (h < hold) begin
        next_cycle();
        ex_hold = (h + 1 < hold);
        #1;
      end
    end
    next_cycle();
    op_valid = 1'b0; ex_hold = 1'b0;
    #1;
    chk_quiet("after_done");
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    rst = 1'b1; op_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0; flush = 1'b0; ex_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_quiet("reset");
    chk("reset_data", {hi_wdata, lo_wdata}, 64'h0);
    chk("reset_ops", {mul_ina, mul_inb}, 64'h0);

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 4, 0);
    chk("mult_m2x3", ref_res(OP_MULT, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_DIVU, 32'd100, 32'd7, 32, 0);
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 3, 3);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 3);

    // divider flushed mid-flight
    dlat = 40;
    next_cycle();
    op_valid = 1'b1; op_code = OP_DIV; src_a = 32'd1234; src_b = 32'd5;
    repeat (9) next_cycle();
    flush = 1'b1;
    #1;
    chk("flush_annul", 64'(div_annul), 64'(1));
    chk("flush_we", 64'({hi_we, lo_we, div_start}), 64'(0));
    next_cycle();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk_quiet("post_flush");
    next_cycle();
    chk_quiet("post_flush2");

    // reset while multiplying
    next_cycle();
    op_valid = 1'b1; op_code = OP_MULT; src_a = 32'd77; src_b = 32'd11;
    next_cycle();
    rst = 1'b1; op_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    chk_quiet("mid_reset");
    chk("mid_reset_data", {hi_wdata, lo_wdata}, 64'h0);
    chk("mid_reset_ops", {mul_ina, mul_inb}, 64'h0);
    chk("mid_reset_sgn", 64'({mul_signed, div_signed}), 64'(0));
    run_op(OP_MULT, 32'd77, 32'd11, 1, 0);

    // flush in the accept cycle, then non-one-hot codes
    next_cycle();
    op_valid = 1'b1; op_code = OP_MULTU; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    #1;
    chk("accept_flush_stall", 64'(stallreq), 64'(0));
    next_cycle();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk_quiet("accept_flush_next");
    foreach (c[i]) begin end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      op_valid = 1'b1;
      op_code = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0011 : 4'b1111;
      #1;
      chk("bad_code_stall", 64'(stallreq), 64'(0));
    end
    next_cycle();
    op_valid = 1'b0;
    #1;
    chk_quiet("bad_code_next");

    // divide by zero: bypassed or sent to the divider depending on the build
    run_op(OP_DIV, 32'h1234_5678, 32'd0, 5, 0);
    run_op(OP_DIVU, 32'hCAFE_0001, 32'd0, 2, 1);

    for (int n = 0; n < 20; n++) begin
      c = 4'b0001 << $urandom_range(0, 3);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (c[1] || c[0]) begin
        if (b == 0) b = 32'd3;
        if (c[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd7;
      end
      run_op(c, a, b, $urandom_range(1, 6), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
